// File: rtl/global_params_pkg.sv
// -----------------------------------------------------------------------------
// global_params : parameters shared between the memory controller and the core.
//   XLEN / ROB_SIZE_WIDTH / INST_OP_WIDTH  datapath, ROB id and op-code widths
//   OP_*                                   store/load op encodings (SB..LHU)
//   mc_state_t                             memory controller FSM encoding
//   IO_BASE                                first I/O-mapped address (I/O cycles
//                                          are ordinary bus cycles)
//   op_len()                               access length in bytes for an op
// -----------------------------------------------------------------------------
package global_params;

    localparam int XLEN           = 32;
    localparam int ROB_SIZE_WIDTH = 4;
    localparam int INST_OP_WIDTH  = 4;

    localparam logic [31:0] IO_BASE = 32'h30000;

    localparam logic [INST_OP_WIDTH-1:0] OP_SB  = 4'd0;
    localparam logic [INST_OP_WIDTH-1:0] OP_SH  = 4'd1;
    localparam logic [INST_OP_WIDTH-1:0] OP_SW  = 4'd2;
    localparam logic [INST_OP_WIDTH-1:0] OP_LB  = 4'd3;
    localparam logic [INST_OP_WIDTH-1:0] OP_LH  = 4'd4;
    localparam logic [INST_OP_WIDTH-1:0] OP_LW  = 4'd5;
    localparam logic [INST_OP_WIDTH-1:0] OP_LBU = 4'd6;
    localparam logic [INST_OP_WIDTH-1:0] OP_LHU = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STORE = 2'd1,
        ST_LOAD  = 2'd2,
        ST_FETCH = 2'd3
    } mc_state_t;

    // Byte count of an access: B = 1, H = 2, W (and anything else) = 4.
    function automatic logic [2:0] op_len(input logic [INST_OP_WIDTH-1:0] op);
        case (op)
            OP_SB, OP_LB, OP_LBU: op_len = 3'd1;
            OP_SH, OP_LH, OP_LHU: op_len = 3'd2;
            default:              op_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memory_controller_store_buffer.sv
// -----------------------------------------------------------------------------
// mem_store_buffer : one-entry holding register for committed stores.
//   clk, rst (sync, active high), rdy (global enable, holds state when low)
//   i_en / i_op / i_addr / i_val   store pulse from the ROB, captured in any
//                                  FSM state
//   i_clear                        last byte of the buffered store written
//   o_valid / o_op / o_addr / o_val  buffered store
//   o_busy                         pulse | valid; the controller ORs in the
//                                  STORE state to form mem_busy
// -----------------------------------------------------------------------------
module mem_store_buffer
    import global_params::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     i_en,
    input  logic [INST_OP_WIDTH-1:0] i_op,
    input  logic [XLEN-1:0]          i_addr,
    input  logic [XLEN-1:0]          i_val,
    input  logic                     i_clear,
    output logic                     o_valid,
    output logic [INST_OP_WIDTH-1:0] o_op,
    output logic [XLEN-1:0]          o_addr,
    output logic [XLEN-1:0]          o_val,
    output logic                     o_busy
);

    logic                     r_valid;
    logic [INST_OP_WIDTH-1:0] r_op;
    logic [XLEN-1:0]          r_addr;
    logic [XLEN-1:0]          r_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_op    <= '0;
            r_addr  <= '0;
            r_val   <= '0;
        end else if (rdy) begin
            // A new pulse wins over a clear; mem_busy keeps the ROB from
            // committing while the entry is occupied, so this never overwrites.
            if (i_en) begin
                r_valid <= 1'b1;
                r_op    <= i_op;
                r_addr  <= i_addr;
                r_val   <= i_val;
            end else if (i_clear) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Includes the raw pulse so a second commit in the very next cycle is held off.
    assign o_busy  = i_en | r_valid;
    assign o_valid = r_valid;
    assign o_op    = r_op;
    assign o_addr  = r_addr;
    assign o_val   = r_val;

endmodule

// File: rtl/memory_controller.sv
// -----------------------------------------------------------------------------
// memory_controller : byte-serial arbiter between the core and the 8-bit RAM/IO
// bus. Serves buffered ROB stores, LSB loads and instruction fetches.
//   clk, rst (sync, active high), rdy (global enable), flush (mispredict)
//   rob_mem_enable/op/addr/val      one-cycle store commit pulse
//   lsb_load_enable/op/addr/id      load request, held until mem_data_ready
//   if_enable/if_addr               fetch request, held until mem_inst_ready
//   mem_din / mem_dout / mem_a / mem_wr   RAM bus (read data one cycle late)
//   mem_busy                        back-pressure to ROB store commit
//   mem_data_ready/mem_data/mem_id  load result pulse
//   mem_inst_ready/mem_inst         fetch result pulse
// Build option: MEM_CTRL_LOAD_PRIORITY_EN -- when defined, IDLE serves a load
// before a fetch; otherwise fetch before load. Stores always go first.
// -----------------------------------------------------------------------------
module memory_controller
    import global_params::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      rob_mem_enable,
    input  logic [INST_OP_WIDTH-1:0]  rob_mem_op,
    input  logic [XLEN-1:0]           rob_mem_addr,
    input  logic [XLEN-1:0]           rob_mem_val,
    input  logic                      lsb_load_enable,
    input  logic [INST_OP_WIDTH-1:0]  lsb_load_op,
    input  logic [XLEN-1:0]           lsb_load_addr,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_load_id,
    input  logic                      if_enable,
    input  logic [XLEN-1:0]           if_addr,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [XLEN-1:0]           mem_a,
    output logic                      mem_wr,
    output logic                      mem_busy,
    output logic                      mem_data_ready,
    output logic [XLEN-1:0]           mem_data,
    output logic [ROB_SIZE_WIDTH-1:0] mem_id,
    output logic                      mem_inst_ready,
    output logic [31:0]               mem_inst
);

    mc_state_t                 r_state, w_state_nxt;
    logic [2:0]                r_cnt, w_cnt_nxt;
    logic [INST_OP_WIDTH-1:0]  r_op;
    logic [XLEN-1:0]           r_addr;
    logic [ROB_SIZE_WIDTH-1:0] r_id;
    logic [23:0]               r_data;   // bytes 0..2; the final byte is taken live from mem_din

    logic                      w_latch_load, w_latch_fetch, w_sb_clear;
    logic                      w_sb_valid, w_sb_busy;
    logic [INST_OP_WIDTH-1:0]  w_sb_op;
    logic [XLEN-1:0]           w_sb_addr, w_sb_val;
    logic [2:0]                w_len;
    logic                      w_resp;
    logic [XLEN-1:0]           w_raw, w_ext;
    logic [7:0]                w_store_byte;

    mem_store_buffer u_sb (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .i_en    (rob_mem_enable),
        .i_op    (rob_mem_op),
        .i_addr  (rob_mem_addr),
        .i_val   (rob_mem_val),
        .i_clear (w_sb_clear),
        .o_valid (w_sb_valid),
        .o_op    (w_sb_op),
        .o_addr  (w_sb_addr),
        .o_val   (w_sb_val),
        .o_busy  (w_sb_busy)
    );

    assign mem_busy = w_sb_busy | (r_state == ST_STORE);

    // Length of the access in progress (fetch is always a word).
    always_comb begin
        w_len = 3'd4;
        case (r_state)
            ST_STORE: w_len = op_len(w_sb_op);
            ST_LOAD:  w_len = op_len(r_op);
            default:  ;
        endcase
    end

    // Next state. Stores run straight from the buffer entry, which stays
    // valid until its last byte is written.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_latch_load  = 1'b0;
        w_latch_fetch = 1'b0;
        w_sb_clear    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!flush) begin
                    if (w_sb_valid) begin
                        w_state_nxt = ST_STORE;
`ifdef MEM_CTRL_LOAD_PRIORITY_EN
                    end else if (lsb_load_enable) begin
                        w_state_nxt  = ST_LOAD;
                        w_latch_load = 1'b1;
                    end else if (if_enable) begin
                        w_state_nxt   = ST_FETCH;
                        w_latch_fetch = 1'b1;
                    end
`else
                    end else if (if_enable) begin
                        w_state_nxt   = ST_FETCH;
                        w_latch_fetch = 1'b1;
                    end else if (lsb_load_enable) begin
                        w_state_nxt  = ST_LOAD;
                        w_latch_load = 1'b1;
                    end
`endif
                end
            end
            ST_STORE: begin
                // flush deliberately ignored: committed stores always finish.
                if (r_cnt == w_len - 3'd1) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_sb_clear  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            default: begin  // ST_LOAD, ST_FETCH
                // cnt 0..n-1 drive addresses, cnt n is the result cycle.
                if (flush || r_cnt == w_len) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_addr  <= '0;
            r_id    <= '0;
            r_data  <= '0;
        end else if (rdy) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch_load) begin
                r_op   <= lsb_load_op;
                r_addr <= lsb_load_addr;
                r_id   <= lsb_load_id;
            end
            if (w_latch_fetch) begin
                r_addr <= if_addr;
            end
            // mem_din carries the byte addressed in the previous cycle.
            if (r_state == ST_LOAD || r_state == ST_FETCH) begin
                case (r_cnt)
                    3'd1:    r_data[7:0]   <= mem_din;
                    3'd2:    r_data[15:8]  <= mem_din;
                    3'd3:    r_data[23:16] <= mem_din;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (r_cnt[1:0])
            2'd0:    w_store_byte = w_sb_val[7:0];
            2'd1:    w_store_byte = w_sb_val[15:8];
            2'd2:    w_store_byte = w_sb_val[23:16];
            default: w_store_byte = w_sb_val[31:24];
        endcase
    end

    // RAM bus. Address outputs idle at zero outside an active beat.
    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = '0;
        case (r_state)
            ST_STORE: begin
                mem_a    = w_sb_addr + XLEN'(r_cnt);
                mem_wr   = rdy;
                mem_dout = w_store_byte;
            end
            ST_LOAD, ST_FETCH: begin
                if (r_cnt < w_len) mem_a = r_addr + XLEN'(r_cnt);
            end
            default: ;
        endcase
    end

    // Result assembly: the last byte arrives in the result cycle itself.
    always_comb begin
        case (w_len)
            3'd1:    w_raw = {24'd0, mem_din};
            3'd2:    w_raw = {16'd0, mem_din, r_data[7:0]};
            default: w_raw = {mem_din, r_data};
        endcase
    end

    // w_raw is already zero-filled, which covers LBU/LHU and LW.
    always_comb begin
        case (r_op)
            OP_LB:   w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
            OP_LH:   w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    assign w_resp         = rdy & ~flush & (r_cnt == w_len);
    assign mem_data_ready = (r_state == ST_LOAD) & w_resp;
    assign mem_data       = mem_data_ready ? w_ext : '0;
    assign mem_id         = mem_data_ready ? r_id : '0;
    assign mem_inst_ready = (r_state == ST_FETCH) & w_resp;
    assign mem_inst       = mem_inst_ready ? {mem_din, r_data} : '0;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a byte RAM model and an ordered
// scoreboard of bus writes, load results and fetch results.
module tb_memory_controller;
    import global_params::*;

    logic                      clk = 1'b0;
    logic                      rst, rdy, flush;
    logic                      rob_mem_enable;
    logic [INST_OP_WIDTH-1:0]  rob_mem_op;
    logic [XLEN-1:0]           rob_mem_addr, rob_mem_val;
    logic                      lsb_load_enable;
    logic [INST_OP_WIDTH-1:0]  lsb_load_op;
    logic [XLEN-1:0]           lsb_load_addr;
    logic [ROB_SIZE_WIDTH-1:0] lsb_load_id;
    logic                      if_enable;
    logic [XLEN-1:0]           if_addr;
    logic [7:0]                mem_din;
    logic [7:0]                mem_dout;
    logic [XLEN-1:0]           mem_a;
    logic                      mem_wr, mem_busy, mem_data_ready, mem_inst_ready;
    logic [XLEN-1:0]           mem_data;
    logic [ROB_SIZE_WIDTH-1:0] mem_id;
    logic [31:0]               mem_inst;

    memory_controller dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .rob_mem_enable(rob_mem_enable), .rob_mem_op(rob_mem_op),
        .rob_mem_addr(rob_mem_addr), .rob_mem_val(rob_mem_val),
        .lsb_load_enable(lsb_load_enable), .lsb_load_op(lsb_load_op),
        .lsb_load_addr(lsb_load_addr), .lsb_load_id(lsb_load_id),
        .if_enable(if_enable), .if_addr(if_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_busy(mem_busy), .mem_data_ready(mem_data_ready), .mem_data(mem_data),
        .mem_id(mem_id), .mem_inst_ready(mem_inst_ready), .mem_inst(mem_inst)
    );

    always #5 clk = ~clk;

    // RAM model: read byte valid one cycle after its address.
    logic [7:0]  ram [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_a  = '0;
    logic [7:0]  pl_d  = '0;
    always @(posedge clk) begin
        if (pl_en)  ram[pl_a] <= pl_d;
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    typedef struct {
        logic [1:0]  k;   // 0 write, 1 load result, 2 fetch result
        logic [31:0] x;
        logic [31:0] y;
    } ev_t;
    ev_t exp_q[$];

    int n_vec = 0, n_err = 0;
    int cyc = 0, ld_cyc = -1, if_cyc = -1, wr_cyc = -1;
    int t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [31:0] x, input logic [31:0] y);
        ev_t e;
        e.k = k; e.x = x; e.y = y;
        exp_q.push_back(e);
    endtask

    task automatic got(input string tag, input logic [1:0] k, input logic [31:0] x, input logic [31:0] y);
        ev_t e;
        n_vec++;
        assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s unexpected observed k=%0d x=%h y=%h expected none", tag, k, x, y);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            assert (k === e.k && x === e.x && y === e.y) else begin
                n_err++;
                $error("FAIL %s observed k=%0d x=%h y=%h expected k=%0d x=%h y=%h",
                       tag, k, x, y, e.k, e.x, e.y);
            end
        end
    endtask

    // One clock: sample outputs at the falling edge, advance past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (mem_wr) begin
            got("write", 2'd0, mem_a, {24'd0, mem_dout});
            if (wr_cyc < 0) wr_cyc = cyc;
        end
        if (mem_data_ready) begin
            got("load", 2'd1, mem_data, 32'(mem_id));
            ld_cyc = cyc;
            lsb_load_enable = 1'b0;
        end
        if (mem_inst_ready) begin
            got("fetch", 2'd2, mem_inst, 32'd0);
            if_cyc = cyc;
            if_enable = 1'b0;
        end
        @(posedge clk);
        #1;
        rob_mem_enable = 1'b0;
        flush = 1'b0;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pl(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic store(input logic [INST_OP_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] v);
        rob_mem_enable = 1'b1; rob_mem_op = op; rob_mem_addr = a; rob_mem_val = v;
    endtask

    task automatic load(input logic [INST_OP_WIDTH-1:0] op, input logic [31:0] a, input logic [3:0] id);
        lsb_load_enable = 1'b1; lsb_load_op = op; lsb_load_addr = a; lsb_load_id = id;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        rob_mem_enable = 1'b0; rob_mem_op = '0; rob_mem_addr = '0; rob_mem_val = '0;
        lsb_load_enable = 1'b0; lsb_load_op = '0; lsb_load_addr = '0; lsb_load_id = '0;
        if_enable = 1'b0; if_addr = '0;
        #1;
        tick();
        store(OP_SW, 32'h700, 32'hFFFF_FFFF);   // must be discarded by reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_mem_busy", 32'(mem_busy), 32'd0);
        chk("rst_data_ready", 32'(mem_data_ready), 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_mem_id", 32'(mem_id), 32'd0);
        chk("rst_inst_ready", 32'(mem_inst_ready), 32'd0);
        chk("rst_mem_inst", mem_inst, 32'd0);

        pl(12'h200, 8'h80);
        pl(12'h000, 8'h13); pl(12'h001, 8'h05); pl(12'h002, 8'h00); pl(12'h003, 8'h00);
        pl(12'h300, 8'hEF); pl(12'h301, 8'hBE); pl(12'h302, 8'hAD); pl(12'h303, 8'hDE);
        pl(12'h400, 8'h34); pl(12'h401, 8'h92);
        tick();

        // SW store: 4 little-endian write beats, busy from pulse through last byte
        push(0, 32'h100, 32'h78); push(0, 32'h101, 32'h56);
        push(0, 32'h102, 32'h34); push(0, 32'h103, 32'h12);
        store(OP_SW, 32'h100, 32'h1234_5678);
        wr_cyc = -1; t = cyc;
        #1;
        chk("sw_busy_pulse", 32'(mem_busy), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("sw_busy", 32'(mem_busy), 32'd1);
            tick();
        end
        #1;
        chk("sw_busy_after", 32'(mem_busy), 32'd0);
        chk("sw_first_beat", 32'(wr_cyc), 32'(t + 2));

        // LB / LBU of 0x80
        push(1, 32'hFFFF_FF80, 32'd5);
        load(OP_LB, 32'h200, 4'd5); t = cyc;
        ticks(4);
        chk("lb_latency", 32'(ld_cyc), 32'(t + 2));
        push(1, 32'h0000_0080, 32'd5);
        load(OP_LBU, 32'h200, 4'd5);
        ticks(4);

        // Fetch word at 0
        push(2, 32'h0000_0513, 32'd0);
        if_enable = 1'b1; if_addr = 32'h0; t = cyc;
        ticks(7);
        chk("fetch_latency", 32'(if_cyc), 32'(t + 5));

        // Store pulse in 2nd cycle of an LW: load first, then store without a gap
        push(1, 32'hDEAD_BEEF, 32'd3);
        push(0, 32'h310, 32'hCD); push(0, 32'h311, 32'hAB);
        load(OP_LW, 32'h300, 4'd3); t = cyc;
        ticks(2);
        store(OP_SH, 32'h310, 32'h0000_ABCD);
        wr_cyc = -1;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk("ldst_busy", 32'(mem_busy), 32'd1);
            tick();
        end
        #1;
        chk("ldst_busy_after", 32'(mem_busy), 32'd0);
        chk("ldst_lw_latency", 32'(ld_cyc), 32'(t + 5));
        chk("ldst_store_start", 32'(wr_cyc), 32'(t + 7));

        // Flush in 3rd cycle of an LH: no result, back in IDLE
        load(OP_LH, 32'h400, 4'd2);
        ticks(2);
        flush = 1'b1; lsb_load_enable = 1'b0;
        #1;
        chk("flush_no_ready", 32'(mem_data_ready), 32'd0);
        tick();
        #1;
        chk("flush_idle", 32'(dut.r_state), 32'(ST_IDLE));
        ticks(2);
        push(1, 32'hFFFF_9234, 32'd2);
        load(OP_LH, 32'h400, 4'd2); t = cyc;
        ticks(5);
        chk("lh_latency", 32'(ld_cyc), 32'(t + 3));

        // Flush during SH: both bytes still written, read back with LHU
        push(0, 32'h500, 32'h6B); push(0, 32'h501, 32'h5A);
        store(OP_SH, 32'h500, 32'h0000_5A6B);
        ticks(2);
        flush = 1'b1;
        ticks(4);
        push(1, 32'h0000_5A6B, 32'd9);
        load(OP_LHU, 32'h500, 4'd9);
        ticks(5);

        // rdy low stalls a store and suppresses mem_wr
        push(0, 32'h600, 32'h77);
        store(OP_SB, 32'h600, 32'h0000_0077);
        ticks(2);
        rdy = 1'b0;
        #1;
        chk("rdy_low_no_wr", 32'(mem_wr), 32'd0);
        ticks(2);
        rdy = 1'b1;
        ticks(3);

        // Load and fetch raised together
`ifdef MEM_CTRL_LOAD_PRIORITY_EN
        push(1, 32'hDEAD_BEEF, 32'd7);
        push(2, 32'h0000_0513, 32'd0);
`else
        push(2, 32'h0000_0513, 32'd0);
        push(1, 32'hDEAD_BEEF, 32'd7);
`endif
        load(OP_LW, 32'h300, 4'd7);
        if_enable = 1'b1; if_addr = 32'h0;
        ticks(14);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
